instruction_loader: RTL
=======================

Name: instruction_loader

Overview:
- Writer side of the instruction memory: receives a program image over a UART serial line and writes it word by word into instruction memory.
- Drives the memory's byte_address / write_enable / write_data port while the fetch stage is held off.
- Raises load_done when the image is complete. Top level uses load_done to release the fetch stage, which then reads from address 0.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (434 = 50 MHz / 115200 baud); minimum 4.
- MEM_WORDS, 1024, instruction memory depth in 32-bit words.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- uart_rx  input  1  serial input, 8N1, LSB first, idle high; asynchronous to clk.
- byte_address  output  32  memory write byte address; always word-aligned.
- write_enable  output  1  one-cycle write strobe.
- write_data  output  32  word to write; valid while write_enable = 1.
- load_done  output  1  high once the whole image has been processed; sticky until rst.
- load_error  output  1  sticky: a framing error or an oversize image occurred.

Behaviour:
- Reset (async, rst = 1): byte_address = 0, write_enable = 0, write_data = 0, load_done = 0, load_error = 0, FSM in LEN with byte counter = 0. Reset mid-load abandons the partial image; memory contents already written are not cleared.
- UART receiver (sub-module):
  - uart_rx passes through a 2-flop synchronizer.
  - A high-to-low transition on the synchronized line starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2. If the line is high there, the frame is a glitch: return to idle with no output.
  - 8 data bits are sampled at CLKS_PER_BIT intervals from the start-bit midpoint, then the stop bit.
  - Stop bit = 1: rx_valid pulses for 1 cycle with rx_data.
  - Stop bit = 0: frame_error pulses for 1 cycle instead; rx_valid stays low.
  - After the stop-bit sample the receiver is ready for the next start edge.
- Stream format: 4-byte word count N, little-endian, then N words, each 4 bytes little-endian.
- FSM states:
  - LEN: collect 4 bytes into N. After the 4th byte: N = 0 -> DONE, else -> DATA with word index = 0.
  - DATA: shift bytes into the word assembly register (byte k lands in bits [8k+7:8k]). After the 4th byte -> WRITE.
  - WRITE: lasts 1 cycle.
    - write_enable = 1, write_data = assembled word, byte_address = index*4.
    - If index >= MEM_WORDS, the write is suppressed (write_enable stays 0) and load_error is set; the word is still consumed.
    - Then index increments. index == N after the increment -> DONE, else -> DATA.
  - DONE: load_done = 1; all further bytes are ignored; leave only on rst.
- Latency: write_enable asserts the cycle after the rx_valid of a word's 4th byte.
- WRITE lasts 1 cycle, which is far shorter than one UART frame, so no byte can be lost.
- byte_address holds its last value when write_enable = 0.
- frame_error in LEN or DATA: the byte is discarded (byte counter unchanged) and load_error is set; the load continues. In DONE, frame errors are ignored.
- Width rules: N and index are 32-bit; index*4 is computed as {index[29:0], 2'b00}.

Decomposition:
- common_pkg additions:
  - loader_state_t enum: LEN, DATA, WRITE, DONE.
  - UART_DEFAULT_CLKS_PER_BIT constant.
  - Reuse the existing memory data/address widths.
- Sub-module uart_receiver (parameter CLKS_PER_BIT; ports clk, rst, rx, rx_data[7:0], rx_valid, frame_error) contains the synchronizer and the bit-timing FSM (IDLE, START, BITS, STOP).
- instruction_loader holds only the stream FSM.

Test Plan (CLKS_PER_BIT = 4, MEM_WORDS = 8):
- Send 02 00 00 00, 13 05 10 00, 93 05 20 00 -> writes 0x00100513 @ 0x0 and 0x00200593 @ 0x4, each as a 1-cycle strobe; load_done = 1 after the 2nd write; load_error = 0.
- Send 00 00 00 00 -> no write_enable pulses; load_done = 1 one cycle after the 4th byte.
- N = 9, 9 words 0xAAAA0000+i -> 8 writes at 0x00..0x1C; 9th write suppressed; load_error = 1; load_done = 1.
- N = 1; corrupt the stop bit of the 2nd data byte, then resend the byte correctly -> load_error = 1; one write of the correct word @ 0x0; load_done = 1.
- 1-cycle low glitch on uart_rx while idle -> no rx_valid, no state change.
- Assert rst mid-word (after 2 data bytes), release, send a full 1-word image -> all outputs 0 during rst; the new image writes @ 0x0 with the correct data.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the UART program loader.
package instruction_loader_pkg;

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned MEM_ADDR_W                = 32;
  localparam int unsigned MEM_DATA_W                = 32;

  typedef enum logic [1:0] {LEN, DATA, WRITE, DONE} loader_state_t;
  typedef enum logic [1:0] {IDLE, START, BITS, STOP} uart_state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Instruction-memory write port plus loader status, driven by the loader.
interface instruction_loader_if;
  import instruction_loader_pkg::*;

  logic [MEM_ADDR_W-1:0] byte_address;
  logic                  write_enable;
  logic [MEM_DATA_W-1:0] write_data;
  logic                  load_done;
  logic                  load_error;

  modport master (
    output byte_address, write_enable, write_data, load_done, load_error
  );
  modport slave (
    input  byte_address, write_enable, write_data, load_done, load_error
  );
endinterface

// File: rtl/instruction_loader_uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, 1-cycle result pulses.
module uart_receiver
  import instruction_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             meta_q, sync_q, prev_q;
  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // A line already back high at mid start bit is a glitch.
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync_q ? IDLE : BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BITS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {sync_q, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          valid_d = sync_q;
          ferr_d  = !sync_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data     = shreg_q;
  assign rx_valid    = valid_q;
  assign frame_error = ferr_q;

endmodule

// File: rtl/instruction_loader.sv
// Receives a length-prefixed little-endian program image over UART and
// writes it word by word into instruction memory.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned MEM_WORDS    = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  instruction_loader_if.master mem
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;

  uart_receiver #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error)
  );

  loader_state_t         state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           len_q, len_d;
  logic [MEM_DATA_W-1:0] word_q, word_d;
  logic [31:0]           idx_q, idx_d;
  logic                  we_q, we_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_DATA_W-1:0] data_q, data_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    case (state_q)
      LEN: begin
        if (frame_error) begin
          err_d = 1'b1;
        end else if (rx_valid) begin
          len_d      = {rx_data, len_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            idx_d   = '0;
            state_d = (len_d == '0) ? DONE : DATA;
          end
        end
      end
      DATA: begin
        if (frame_error) begin
          err_d = 1'b1;
        end else if (rx_valid) begin
          word_d     = {rx_data, word_q[MEM_DATA_W-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Strobe registered here so it is visible during the WRITE cycle.
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
            if (idx_q < MEM_WORDS) begin
              we_d   = 1'b1;
              addr_d = {idx_q[29:0], 2'b00};
              data_d = word_d;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      WRITE: begin
        idx_d   = idx_q + 32'd1;
        state_d = (idx_d == len_q) ? DONE : DATA;
      end
      DONE: ;
      default: state_d = DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LEN;
      byte_cnt_q <= '0;
      len_q      <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign mem.byte_address = addr_q;
  assign mem.write_enable = we_q;
  assign mem.write_data   = data_q;
  assign mem.load_done    = (state_q == DONE);
  assign mem.load_error   = err_q;

endmodule
